// File: rtl/saturn_bus_arbiter.sv
// Saturn nibble-bus arbiter: 4-phase bus sequencer plus round-robin burst grants
// between M0 (CPU bus controller) and M1 (debug/DMA engine).
// state | meaning
// IDLE  | no owner, bus outputs driven to 0
// OWN0  | M0 owns the current bus cycle
// OWN1  | M1 owns the current bus cycle
module saturn_bus_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int CTR_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clk_en,
  input  logic             i_stall,
  input  logic             i_m0_req,
  input  logic             i_m0_is_data,
  input  logic [3:0]       i_m0_nibble,
  input  logic             i_m0_last,
  input  logic             i_m1_req,
  input  logic             i_m1_is_data,
  input  logic [3:0]       i_m1_nibble,
  input  logic             i_m1_last,
  input  logic [3:0]       i_bus_nibble_in,
  output logic             o_m0_gnt,
  output logic             o_m1_gnt,
  output logic [3:0]       o_rd_nibble,
  output logic             o_m0_rd_valid,
  output logic             o_m1_rd_valid,
  output logic             o_bus_clk_en,
  output logic             o_bus_is_data,
  output logic [3:0]       o_bus_nibble_out,
  output logic [3:0]       o_phases,
  output logic [1:0]       o_phase,
  output logic [CTR_W-1:0] o_cycle_ctr,
  output logic             o_timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

  state_t     state;
  state_t     pick;
  logic       rr_m1;
  logic [7:0] burst_cnt;
  logic [7:0] burst_inc;
  logic       advance;
  logic       cycle_end;
  logic       own_req;
  logic       own_last;
  logic       strobe;
  logic       burst_done;
  logic       forced;
  logic       next_ptr_m1;

  always_comb begin
    advance          = i_clk_en && !i_stall;
    cycle_end        = advance && (o_phase == 2'd3);
    own_req          = 1'b0;
    own_last         = 1'b0;
    o_bus_is_data    = 1'b0;
    o_bus_nibble_out = 4'h0;
    case (state)
      OWN0: begin
        own_req          = i_m0_req;
        own_last         = i_m0_last;
        o_bus_is_data    = i_m0_is_data;
        o_bus_nibble_out = i_m0_nibble;
      end
      OWN1: begin
        own_req          = i_m1_req;
        own_last         = i_m1_last;
        o_bus_is_data    = i_m1_is_data;
        o_bus_nibble_out = i_m1_nibble;
      end
      default: ;
    endcase
    strobe     = cycle_end && own_req;
    burst_inc  = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;
    // a dropped request releases the bus at the boundary without a strobe
    burst_done = !own_req || own_last || (burst_inc >= BURST_LIM);
    forced     = strobe && !own_last && (burst_inc == BURST_LIM);
    // on release the other master gets priority for the tie-break
    next_ptr_m1 = (state == IDLE) ? rr_m1 : (state == OWN0);
    pick = IDLE;
    if (i_m0_req && i_m1_req) pick = next_ptr_m1 ? OWN1 : OWN0;
    else if (i_m0_req)        pick = OWN0;
    else if (i_m1_req)        pick = OWN1;
  end

  assign o_bus_clk_en = strobe;
  assign o_m0_gnt     = (state == OWN0);
  assign o_m1_gnt     = (state == OWN1);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      rr_m1         <= 1'b0;
      burst_cnt     <= 8'd0;
      o_phases      <= 4'b0001;
      o_phase       <= 2'd0;
      o_cycle_ctr   <= '0;
      o_rd_nibble   <= 4'h0;
      o_m0_rd_valid <= 1'b0;
      o_m1_rd_valid <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      o_m0_rd_valid <= strobe && (state == OWN0);
      o_m1_rd_valid <= strobe && (state == OWN1);
      o_timeout     <= forced;
      if (strobe) o_rd_nibble <= i_bus_nibble_in;
      if (advance) begin
        o_phases <= {o_phases[2:0], o_phases[3]};
        o_phase  <= o_phase + 2'd1;
      end
      if (cycle_end) begin
        o_cycle_ctr <= o_cycle_ctr + CTR_W'(1);
        if (state == IDLE) begin
          state <= pick;
        end else if (burst_done) begin
          state     <= pick;
          rr_m1     <= next_ptr_m1;
          burst_cnt <= 8'd0;
        end else begin
          burst_cnt <= burst_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_saturn_bus_arbiter.sv
// Bench for saturn_bus_arbiter: directed scenarios plus random traffic, all checked
// every clock against a bus-cycle level reference model.
module tb_saturn_bus_arbiter;

  localparam int MAXB = 4;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst_n, clk_en, stall;
  logic          m0_req, m0_is_data, m0_last, m1_req, m1_is_data, m1_last;
  logic [3:0]    m0_nibble, m1_nibble, bus_in;
  logic          m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid, bus_clk_en, bus_is_data, timeout;
  logic [3:0]    rd_nibble, bus_nibble_out, phases;
  logic [1:0]    phase;
  logic [CW-1:0] cycle_ctr;

  always #5 clk = ~clk;

  saturn_bus_arbiter #(.MAX_BURST(MAXB), .CTR_W(CW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_clk_en(clk_en), .i_stall(stall),
    .i_m0_req(m0_req), .i_m0_is_data(m0_is_data), .i_m0_nibble(m0_nibble), .i_m0_last(m0_last),
    .i_m1_req(m1_req), .i_m1_is_data(m1_is_data), .i_m1_nibble(m1_nibble), .i_m1_last(m1_last),
    .i_bus_nibble_in(bus_in),
    .o_m0_gnt(m0_gnt), .o_m1_gnt(m1_gnt), .o_rd_nibble(rd_nibble),
    .o_m0_rd_valid(m0_rd_valid), .o_m1_rd_valid(m1_rd_valid),
    .o_bus_clk_en(bus_clk_en), .o_bus_is_data(bus_is_data), .o_bus_nibble_out(bus_nibble_out),
    .o_phases(phases), .o_phase(phase), .o_cycle_ctr(cycle_ctr), .o_timeout(timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: owner -1 = nobody, 0 = M0, 1 = M1
  int       m_phase, m_ctr, m_owner, m_rr, m_burst;
  bit [3:0] m_rd;
  bit       m_v0, m_v1, m_to;

  int s0, s1, to_cnt, gnt0_at_to;
  int strobe_owner_q[$];
  int strobe_nib_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(input bit r0, input bit r1, input int rr);
    if (r0 && r1) return rr;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic bit own_req();
    return (m_owner == 0) ? m0_req : (m_owner == 1) ? m1_req : 1'b0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ctr = 0; m_owner = -1; m_rr = 0; m_burst = 0;
    m_rd = 4'h0; m_v0 = 0; m_v1 = 0; m_to = 0;
  endtask

  task automatic model_tick();
    bit adv, at_end, oreq, olast, stb;
    int nb;
    if (!rst_n) begin
      model_reset();
      return;
    end
    adv    = clk_en && !stall;
    at_end = adv && (m_phase == 3);
    oreq   = own_req();
    olast  = (m_owner == 0) ? m0_last : (m_owner == 1) ? m1_last : 1'b0;
    stb    = at_end && oreq;
    nb     = (m_burst < 255) ? m_burst + 1 : 255;
    m_v0 = stb && (m_owner == 0);
    m_v1 = stb && (m_owner == 1);
    m_to = 0;
    if (stb) m_rd = bus_in;
    if (adv) m_phase = (m_phase + 1) % 4;
    if (at_end) begin
      m_ctr = (m_ctr + 1) % (1 << CW);
      if (m_owner < 0) begin
        m_owner = pick(m0_req, m1_req, m_rr);
      end else if (!oreq || olast || nb >= MAXB) begin
        if (stb && !olast && nb == MAXB) m_to = 1;
        m_rr    = 1 - m_owner;
        m_owner = pick(m0_req, m1_req, m_rr);
        m_burst = 0;
      end else begin
        m_burst = nb;
      end
    end
  endtask

  task automatic check_regs();
    chk("phases", {28'd0, phases}, 32'(1 << m_phase));
    chk("phase", {30'd0, phase}, 32'(m_phase));
    chk("cycle_ctr", {24'd0, cycle_ctr}, 32'(m_ctr));
    chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, m_owner == 0});
    chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, m_owner == 1});
    chk("gnt_excl", {31'd0, m0_gnt && m1_gnt}, 32'd0);
    chk("rd_nibble", {28'd0, rd_nibble}, {28'd0, m_rd});
    chk("m0_rd_valid", {31'd0, m0_rd_valid}, {31'd0, m_v0});
    chk("m1_rd_valid", {31'd0, m1_rd_valid}, {31'd0, m_v1});
    chk("timeout", {31'd0, timeout}, {31'd0, m_to});
  endtask

  task automatic check_comb();
    bit exp_stb;
    bit exp_data;
    bit [3:0] exp_nib;
    exp_stb  = rst_n && clk_en && !stall && (m_phase == 3) && own_req();
    exp_data = (m_owner == 0) ? m0_is_data : (m_owner == 1) ? m1_is_data : 1'b0;
    exp_nib  = (m_owner == 0) ? m0_nibble : (m_owner == 1) ? m1_nibble : 4'h0;
    chk("bus_clk_en", {31'd0, bus_clk_en}, {31'd0, exp_stb});
    chk("bus_is_data", {31'd0, bus_is_data}, {31'd0, exp_data});
    chk("bus_nibble_out", {28'd0, bus_nibble_out}, {28'd0, exp_nib});
  endtask

  // called shortly after a rising edge, with inputs for the coming edge already set
  task automatic cycle();
    #1 check_comb();
    if (bus_clk_en) begin
      if (m0_gnt) s0++;
      if (m1_gnt) s1++;
      strobe_owner_q.push_back(m1_gnt ? 1 : 0);
      strobe_nib_q.push_back(int'(bus_nibble_out));
    end
    @(posedge clk);
    model_tick();
    #1 check_regs();
    if (timeout) begin
      to_cnt++;
      gnt0_at_to = m0_gnt;
    end
  endtask

  task automatic clear_inputs();
    clk_en = 1; stall = 0;
    m0_req = 0; m0_is_data = 0; m0_nibble = 0; m0_last = 0;
    m1_req = 0; m1_is_data = 0; m1_nibble = 0; m1_last = 0;
    bus_in = 0;
  endtask

  task automatic clear_stats();
    s0 = 0; s1 = 0; to_cnt = 0; gnt0_at_to = 0;
    strobe_owner_q.delete();
    strobe_nib_q.delete();
  endtask

  task automatic do_reset(input int hold);
    rst_n = 0;
    #1 model_reset();
    check_regs();
    for (int i = 0; i < hold; i++) cycle();
    rst_n = 1;
  endtask

  int stall_left = 0;

  initial begin
    clear_inputs();
    clear_stats();
    rst_n = 1;
    @(posedge clk);
    #1 do_reset(2);

    // idle sequencing: 8 advances, no requests
    for (int i = 0; i < 8; i++) cycle();
    chk("idle_ctr", {24'd0, cycle_ctr}, 32'd2);
    chk("idle_strobes", 32'(s0 + s1), 32'd0);

    // M0 three-nibble burst A,B,C with last on the third
    clear_stats();
    m0_req = 1;
    for (int k = 0; k < 64 && s0 < 3; k++) begin
      m0_nibble = 4'hA + 4'(s0);
      m0_last   = (s0 == 2);
      m0_is_data = 1;
      cycle();
    end
    chk("burst_strobes", 32'(s0), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("burst_nibble", (i < strobe_nib_q.size()) ? 32'(strobe_nib_q[i]) : 32'hDEAD, 32'hA + 32'(i));
    clear_inputs();
    for (int i = 0; i < 8; i++) cycle();

    // both masters, single-cycle bursts, after reset: M0,M1,M0,M1
    do_reset(1);
    clear_stats();
    m0_req = 1; m1_req = 1; m0_last = 1; m1_last = 1;
    for (int k = 0; k < 64 && strobe_owner_q.size() < 4; k++) cycle();
    for (int i = 0; i < 4; i++)
      chk("rr_order", (i < strobe_owner_q.size()) ? 32'(strobe_owner_q[i]) : 32'hDEAD, 32'(i % 2));
    clear_inputs();
    for (int i = 0; i < 8; i++) cycle();

    // M1 holds last low: forced release after MAXB strobes, waiting M0 takes over
    do_reset(1);
    clear_stats();
    m1_req = 1;
    for (int k = 0; k < 16 && !m1_gnt; k++) cycle();
    m0_req = 1;
    for (int k = 0; k < 64 && to_cnt == 0; k++) cycle();
    chk("timeout_strobes", 32'(s1), 32'(MAXB));
    chk("timeout_pulses", 32'(to_cnt), 32'd1);
    chk("timeout_handover", 32'(gnt0_at_to), 32'd1);
    cycle();
    chk("timeout_one_clk", {31'd0, timeout}, 32'd0);

    // stall in phase 3 mid-burst: frozen for 5 clks, single strobe after release
    clear_inputs();
    m0_req = 1;
    for (int k = 0; k < 32 && !(m_owner == 0 && m_phase == 3); k++) cycle();
    clear_stats();
    stall = 1;
    for (int i = 0; i < 5; i++) cycle();
    chk("stall_phase", {30'd0, phase}, 32'd3);
    chk("stall_strobes", 32'(s0), 32'd0);
    stall = 0;
    cycle();
    chk("stall_release_strobe", 32'(s0), 32'd1);
    clear_inputs();

    // reset while M1 owns the bus in phase 2
    m1_req = 1;
    for (int k = 0; k < 64 && !(m_owner == 1 && m_phase == 2); k++) cycle();
    chk("pre_reset_m1", {31'd0, m1_gnt}, 32'd1);
    rst_n = 0;
    #1;
    chk("reset_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);
    chk("reset_phases", {28'd0, phases}, 32'd1);
    chk("reset_ctr", {24'd0, cycle_ctr}, 32'd0);
    model_reset();
    clear_stats();
    m0_req = 1; m1_req = 1; m0_last = 1; m1_last = 1;
    cycle();
    rst_n = 1;
    for (int k = 0; k < 32 && strobe_owner_q.size() == 0; k++) cycle();
    chk("reset_tie_m0", (strobe_owner_q.size() > 0) ? 32'(strobe_owner_q[0]) : 32'hDEAD, 32'd0);

    // random traffic
    clear_inputs();
    for (int n = 0; n < 4000; n++) begin
      clk_en = ($urandom_range(0, 9) != 0);
      if (stall_left > 0) begin
        stall = 1;
        stall_left--;
      end else begin
        stall = 0;
        if ($urandom_range(0, 39) == 0) stall_left = $urandom_range(1, 5);
      end
      if ($urandom_range(0, 7) == 0) m0_req = ~m0_req;
      if ($urandom_range(0, 7) == 0) m1_req = ~m1_req;
      m0_last    = ($urandom_range(0, 2) == 0);
      m1_last    = ($urandom_range(0, 3) == 0);
      m0_is_data = 1'($urandom);
      m1_is_data = 1'($urandom);
      m0_nibble  = 4'($urandom);
      m1_nibble  = 4'($urandom);
      bus_in     = 4'($urandom);
      if ($urandom_range(0, 999) == 0) do_reset($urandom_range(0, 2));
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
